apb_gpio_arbiter: RTL and testbench
===================================

# apb_gpio_arbiter

Round-robin APB master that shares one APB GPIO slave (pad direction/output/interrupt registers) between `NUM_REQ` on-chip requesters, such as the core, a debug unit and a DMA-style sequencer. Each requester issues single-word read/write requests over a req/gnt handshake. The block serialises them into spec-compliant APB SETUP/ACCESS transfers and returns read data and error per transfer. A watchdog aborts transfers whose PREADY never arrives.

## Interface
- `NUM_REQ`, 4: number of requester ports (2..8).
- `APB_ADDR_WIDTH`, 12: APB address width.
- `TIMEOUT_CYCLES`, 255: max ACCESS cycles before abort; 0 disables the watchdog.
- Reset is `HRESETn`, asynchronous, active-low; the clock is `HCLK`.
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  asynchronous active-low reset.
- `req_i`  in  NUM_REQ  per-requester request.
- `req_addr_i`  in  NUM_REQ×APB_ADDR_WIDTH  per-requester byte address.
- `req_we_i`  in  NUM_REQ  1 = write.
- `req_wdata_i`  in  NUM_REQ×32  write data.
- `gnt_o`  out  NUM_REQ  one-hot grant, combinational, at most one bit set.
- `rvalid_o`  out  NUM_REQ  one-hot completion pulse.
- `rdata_o`  out  32  read data of completed transfer (shared).
- `err_o`  out  1  completed transfer errored (PSLVERR or timeout).
- `PADDR`/`PWDATA`/`PWRITE`  out  APB_ADDR_WIDTH/32/1  registered APB master fields.
- `PSEL`, `PENABLE`  out  1  registered APB control.
- `PRDATA`  in  32  slave read data.
- `PREADY`  in  1  slave ready.
- `PSLVERR`  in  1  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0.
  - If any `req_i` is set, raise `gnt_o[w]` for the winner `w`, capture its addr/we/wdata into the PADDR/PWRITE/PWDATA registers and store owner=`w`, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, and the watchdog counter increments each cycle.
  - PREADY=1: capture PRDATA and PSLVERR. The next cycle pulses `rvalid_o[owner]` with `rdata_o`/`err_o`. The same cycle arbitrates again: if any `req_i` is set, grant and go to SETUP (back-to-back); otherwise go to IDLE.
  - Counter reaches TIMEOUT_CYCLES with PREADY=0: abort by going to IDLE, so PSEL/PENABLE drop the next cycle. The next cycle pulses `rvalid_o[owner]` with `err_o`=1 and `rdata_o`=0. No grant is issued in the abort cycle.
- Arbitration: round-robin starting at index `last_grant+1` mod NUM_REQ. `last_grant` updates only on a grant.
- Requester rules: hold req/addr/we/wdata stable until it samples `gnt_o`=1. Deassert or present the next request the following cycle.
- `rdata_o` is the captured PRDATA for both reads and writes; requesters ignore it on writes.
- PADDR/PWDATA/PWRITE hold their last value in IDLE.

## Timing
- Reset values: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `last_grant`=NUM_REQ-1 (so requester 0 wins first), watchdog=0.
- `gnt_o` is 0 in reset and in SETUP.
- Latency with a zero-wait slave: request in cycle 0 (IDLE) gets `gnt` in cycle 0, SETUP in cycle 1, ACCESS+PREADY in cycle 2, `rvalid` in cycle 3.
- Throughput: back-to-back transfers run at one per 2 cycles. PSEL stays high across them; PENABLE toggles 1→0.
- Simultaneous completion and new request: the grant happens in the PREADY cycle, and `rvalid` for the old owner appears in the next cycle (the new SETUP cycle).
- A requester may receive a new `gnt` in the same cycle as its own `rvalid`.
- Wait states: ACCESS holds all APB outputs stable until PREADY or timeout.
- Watchdog: clears on entering SETUP. With TIMEOUT_CYCLES=N, the abort occurs on the Nth ACCESS cycle without PREADY.
- Reset mid-transfer: immediate return to reset values. The pending requester receives no `rvalid` and must re-request.

## Structure
- Package `apb_gpio_arb_pkg`:
  - FSM state enum.
  - GPIO register offset constants: PADDIR 0x00, PADIN 0x08, PADOUT 0x10, INTEN 0x18, INTTYPE0 0x20, INTTYPE1 0x28, INTSTATUS 0x30.
- Sub-module `apb_gpio_rr_arb`: combinational round-robin picker.
  - Inputs: `req`, `last_grant`.
  - Outputs: one-hot `gnt`, index, `any`.

## Test plan
- Single write: req0 writes 0x10 ← 0xA5A5_0F0F with a zero-wait slave → gnt0 cycle 0; PSEL cycle 1; PENABLE cycle 2 with PADDR=0x10 and PWDATA=0xA5A5_0F0F; rvalid0 cycle 3, err=0.
- Read with 3 wait states: req2 reads 0x30, slave returns PRDATA=0x1 after 3 extra cycles → ACCESS lasts 4 cycles with stable outputs; rvalid2 with rdata=0x1.
- Round-robin fairness: all 4 requesters assert continuously → grant order 0,1,2,3,0. PSEL stays high, and a transfer completes every 2 cycles.
- Timeout: TIMEOUT_CYCLES=8, slave never ready → PSEL drops after 8 ACCESS cycles; rvalid with err=1, rdata=0; the next request proceeds normally.
- PSLVERR: slave asserts PREADY=1 and PSLVERR=1 on a write to 0x08 → err=1 reported to the owner only.
- Reset mid-ACCESS: HRESETn low during ACCESS → PSEL/PENABLE are 0 immediately, no rvalid, and req0 wins first after release.

Source files
------------

// File: rtl/apb_gpio_arb_pkg.sv
// Shared types and constants for the APB GPIO round-robin arbiter.
package apb_gpio_arb_pkg;

  // APB master phase: IDLE (bus free), SETUP (PSEL only), ACCESS (PSEL+PENABLE).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Register map of the APB GPIO slave (byte offsets).
  localparam logic [11:0] PADDIR    = 12'h000;
  localparam logic [11:0] PADIN     = 12'h008;
  localparam logic [11:0] PADOUT    = 12'h010;
  localparam logic [11:0] INTEN     = 12'h018;
  localparam logic [11:0] INTTYPE0  = 12'h020;
  localparam logic [11:0] INTTYPE1  = 12'h028;
  localparam logic [11:0] INTSTATUS = 12'h030;

endpackage

// File: rtl/apb_gpio_rr_arb.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps, so the most recent winner has lowest priority.
module apb_gpio_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated order and take the first active one.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// Round-robin APB master sharing one APB GPIO slave between NUM_REQ requesters.
//
// Requester handshake: a requester raises req_i[n] with addr/we/wdata and
// holds all of them stable until it sees gnt_o[n]=1 in a cycle; that cycle is
// the transfer of ownership. From the next cycle it may drop req_i[n] or
// present a new request. Completion is a one-cycle rvalid_o[n] pulse with
// rdata_o/err_o valid in that same cycle; there is no back-pressure on it.
module apb_gpio_arbiter
  import apb_gpio_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     HCLK,
  input  logic                                     HRESETn,
  input  logic [NUM_REQ-1:0]                       req_i,
  input  logic [NUM_REQ-1:0][APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]                       req_we_i,
  input  logic [NUM_REQ-1:0][31:0]                 req_wdata_i,
  output logic [NUM_REQ-1:0]                       gnt_o,
  output logic [NUM_REQ-1:0]                       rvalid_o,
  output logic [31:0]                              rdata_o,
  output logic                                     err_o,
  output logic [APB_ADDR_WIDTH-1:0]                PADDR,
  output logic [31:0]                              PWDATA,
  output logic                                     PWRITE,
  output logic                                     PSEL,
  output logic                                     PENABLE,
  input  logic [31:0]                              PRDATA,
  input  logic                                     PREADY,
  input  logic                                     PSLVERR,
  output state_t                                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen during the last allowed ACCESS cycle.
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    owner, last_grant;
  logic [WD_W-1:0]     wd;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                take, complete, abort;

  apb_gpio_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req        (req_i),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  assign dbg_state = state;

  // Next-state, grant and completion decode for the APB phase machine.
  always_comb begin
    state_nx = state;
    gnt_o    = '0;
    take     = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (HRESETn && arb_any) begin
          gnt_o    = arb_gnt;
          take     = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          if (arb_any) begin
            gnt_o    = arb_gnt;
            take     = 1'b1;
            state_nx = SETUP;
          end else begin
            state_nx = IDLE;
          end
        end else if (WD_EN && (wd == WD_LAST)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Phase register plus PSEL/PENABLE registered from the next phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      state   <= state_nx;
      PSEL    <= (state_nx != IDLE);
      PENABLE <= (state_nx == ACCESS);
    end
  end

  // Capture the winner's transfer fields and remember who owns the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR      <= '0;
      PWDATA     <= '0;
      PWRITE     <= 1'b0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (take) begin
      PADDR      <= req_addr_i[arb_idx];
      PWDATA     <= req_wdata_i[arb_idx];
      PWRITE     <= req_we_i[arb_idx];
      owner      <= arb_idx;
      last_grant <= arb_idx;
    end
  end

  // Watchdog: counts ACCESS cycles, restarted whenever a new SETUP begins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd <= '0;
    end else if (state_nx == SETUP) begin
      wd <= '0;
    end else if (state == ACCESS) begin
      wd <= wd + 1'b1;
    end
  end

  // Completion pulse to the owner one cycle after PREADY or the abort.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= '0;
      if (complete) begin
        rvalid_o <= NUM_REQ'(1) << owner;
        rdata_o  <= PRDATA;
        err_o    <= PSLVERR;
      end else if (abort) begin
        rvalid_o <= NUM_REQ'(1) << owner;
        rdata_o  <= '0;
        err_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Bench for apb_gpio_arbiter: directed scenarios plus random traffic against
// a transaction-level model (round-robin order, register memory, error rule).
module tb_apb_gpio_arbiter;
  import apb_gpio_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  req_addr_i;
  logic [N-1:0]          req_we_i;
  logic [N-1:0][31:0]    req_wdata_i;
  logic [N-1:0]          gnt_o, rvalid_o;
  logic [31:0]           rdata_o;
  logic                  err_o;
  logic [AW-1:0]         PADDR;
  logic [31:0]           PWDATA, PRDATA;
  logic                  PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  state_t                dbg_state;

  apb_gpio_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- APB GPIO slave model ----------------
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  int wcnt = 0;
  int waits = 0;
  bit never_ready = 0;
  bit rand_waits = 0;

  assign PREADY  = PSEL && PENABLE && !never_ready && (wcnt >= waits);
  assign PSLVERR = PREADY && PWRITE && (PADDR == PADIN);
  assign PRDATA  = PREADY ? mem[PADDR[5:3]] : 32'h0;

  always @(posedge HCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PSEL && !PENABLE && rand_waits) waits <= $urandom_range(0, 3);
    if (PREADY && PWRITE && !PSLVERR) mem[PADDR[5:3]] <= PWDATA;
  end

  // ---------------- scoreboard ----------------
  // entry: [35] compare rdata, [34] err, [33:32] owner, [31:0] rdata
  logic [35:0]   exp_q[$];
  logic [35:0]   mon_e;
  int            rr_last = N - 1;
  int            mon_w;
  logic [1:0]    mon_p;
  bit            mon_on = 0;
  bit            mon_bad;
  logic [N-1:0]  gnt_seen = '0;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_we;
  int            done_cnt = 0;
  int            issued = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    logic [1:0] p;
    for (int k = 1; k <= N; k++) begin
      p = 2'((last + k) % N);
      if (r[p]) return int'(p);
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[2'(k)]) return k;
    return -1;
  endfunction

  // Monitor: APB field stability, completion scoreboard, grant order.
  always @(negedge HCLK) begin
    gnt_seen = '0;
    if (HRESETn && mon_on) begin
      if (PSEL) check("apb_fields", 64'({PADDR, PWRITE, PWDATA}), 64'({cur_addr, cur_we, cur_wdata}));
      if (rvalid_o != '0) begin
        done_cnt++;
        if (exp_q.size() == 0) check("rvalid_unexpected", 64'(rvalid_o), 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("rvalid_owner", 64'(rvalid_o), 64'd1 << mon_e[33:32]);
          check("err", 64'(err_o), 64'(mon_e[34]));
          if (mon_e[35]) check("rdata", 64'(rdata_o), 64'(mon_e[31:0]));
        end
      end
      if (gnt_o != '0) begin
        mon_w = rr_pick(req_i, rr_last);
        check("gnt_onehot", 64'($countones(gnt_o)), 64'd1);
        check("gnt_rr", 64'(gnt_o), (mon_w < 0) ? 64'd0 : (64'd1 << mon_w));
        gnt_seen = gnt_o;
        if (mon_w >= 0) begin
          mon_p     = 2'(mon_w);
          rr_last   = mon_w;
          cur_addr  = req_addr_i[mon_p];
          cur_we    = req_we_i[mon_p];
          cur_wdata = req_wdata_i[mon_p];
          if (never_ready) exp_q.push_back({1'b1, 1'b1, mon_p, 32'h0});
          else if (cur_we) begin
            mon_bad = (cur_addr == PADIN);
            if (!mon_bad) ref_mem[cur_addr[5:3]] = cur_wdata;
            exp_q.push_back({1'b0, mon_bad, mon_p, 32'h0});
          end else exp_q.push_back({1'b1, 1'b0, mon_p, ref_mem[cur_addr[5:3]]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int mode = 0;   // 0: drop after grant, 1: random traffic, 2: always re-request
  int budget [N];
  logic [AW-1:0] offs [7];

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic we, input logic [31:0] d);
    logic [1:0] p;
    p = 2'(i);
    req_i[p] = 1'b1; req_addr_i[p] = a; req_we_i[p] = we; req_wdata_i[p] = d;
  endtask

  task automatic new_txn(input int i);
    logic [2:0] o;
    o = 3'($urandom_range(0, 6));
    set_req(i, offs[o], 1'($urandom_range(0, 1)), $urandom);
    issued++;
  endtask

  task automatic step();
    logic [1:0] p;
    @(posedge HCLK); #1;
    for (int i = 0; i < N; i++) begin
      p = 2'(i);
      if (gnt_seen[p]) begin
        if (mode == 2 || (mode == 1 && budget[i] > 0 && $urandom_range(0, 1) == 1)) begin
          new_txn(i);
          if (mode == 1) budget[i]--;
        end else req_i[p] = 1'b0;
      end else if (!req_i[p] && mode == 1 && budget[i] > 0 && $urandom_range(0, 3) == 0) begin
        new_txn(i);
        budget[i]--;
      end
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_psel"},    64'(PSEL), 64'd0);
    check({pfx, "_penable"}, 64'(PENABLE), 64'd0);
    check({pfx, "_pwrite"},  64'(PWRITE), 64'd0);
    check({pfx, "_paddr"},   64'(PADDR), 64'd0);
    check({pfx, "_pwdata"},  64'(PWDATA), 64'd0);
    check({pfx, "_rvalid"},  64'(rvalid_o), 64'd0);
    check({pfx, "_rdata"},   64'(rdata_o), 64'd0);
    check({pfx, "_err"},     64'(err_o), 64'd0);
    check({pfx, "_gnt"},     64'(gnt_o), 64'd0);
    check({pfx, "_state"},   64'(dbg_state), 64'(IDLE));
  endtask

  task automatic reset_dut();
    HRESETn = 1'b0;
    req_i = '0;
    exp_q.delete();
    rr_last = N - 1;
    never_ready = 0;
    repeat (2) @(posedge HCLK);
    #1;
    req_i = 4'b1011;
    #1;
    check_reset("rst");
    req_i = '0;
    HRESETn = 1'b1;
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 0;
    mode = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      step();
      ok = (req_i == '0) && (exp_q.size() == 0) && !PSEL;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic [N-1:0] exp_v, input logic exp_err,
                           output int acc, output logic [31:0] rd);
    bit got;
    got = 0; acc = 0; rd = '0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE) acc++;
      if (rvalid_o != '0) begin
        got = 1;
        check({tag, "_rvalid"}, 64'(rvalid_o), 64'(exp_v));
        check({tag, "_err"}, 64'(err_o), 64'(exp_err));
        rd = rdata_o;
      end
      step();
    end
    check({tag, "_done"}, 64'(got), 64'd1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_single_write();
    set_req(0, PADOUT, 1'b1, 32'hA5A5_0F0F);
    @(negedge HCLK);
    check("sw_gnt_c0", 64'(gnt_o), 64'd1);
    step();
    @(negedge HCLK);
    check("sw_setup_c1", 64'({PSEL, PENABLE}), 64'b10);
    step();
    @(negedge HCLK);
    check("sw_access_c2", 64'({PSEL, PENABLE}), 64'b11);
    check("sw_paddr", 64'(PADDR), 64'(PADOUT));
    check("sw_pwdata", 64'(PWDATA), 64'hA5A5_0F0F);
    check("sw_pwrite", 64'(PWRITE), 64'd1);
    step();
    @(negedge HCLK);
    check("sw_rvalid_c3", 64'(rvalid_o), 64'd1);
    check("sw_err", 64'(err_o), 64'd0);
    drain("sw_drain");
  endtask

  task automatic test_read_waits();
    int acc;
    logic [31:0] rd;
    mem[6] = 32'h1;
    ref_mem[6] = 32'h1;
    waits = 3;
    set_req(2, INTSTATUS, 1'b0, 32'h0);
    wait_done("rd3", 4'b0100, 1'b0, acc, rd);
    check("rd3_access_cycles", 64'(acc), 64'd4);
    check("rd3_rdata", 64'(rd), 64'd1);
    waits = 0;
    drain("rd3_drain");
  endtask

  task automatic test_fairness();
    int gcnt, rcnt, low, last_c, gap_bad;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    gcnt = 0; rcnt = 0; low = 0; last_c = -1; gap_bad = 0;
    reset_dut();
    mode = 2;
    for (int i = 0; i < N; i++) new_txn(i);
    for (int c = 0; c < 30 && gcnt < 5; c++) begin
      @(negedge HCLK);
      if (c > 0 && !PSEL) low++;
      if (rvalid_o != '0) rcnt++;
      if (gnt_o != '0) begin
        order[gcnt] = onehot_idx(gnt_o);
        if (last_c >= 0 && (c - last_c) != 2) gap_bad++;
        last_c = c;
        gcnt++;
      end
      step();
    end
    check("rr_grants", 64'(gcnt), 64'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 64'(order[k]), 64'(exp_order[k]));
    check("rr_gap", 64'(gap_bad), 64'd0);
    check("rr_psel_low", 64'(low), 64'd0);
    check("rr_rvalids", 64'(rcnt), 64'd3);
    drain("rr_drain");
  endtask

  task automatic test_pslverr();
    int acc;
    logic [31:0] rd;
    set_req(1, PADIN, 1'b1, $urandom);
    wait_done("slverr", 4'b0010, 1'b1, acc, rd);
    drain("slverr_drain");
  endtask

  task automatic test_timeout();
    int acc, acc2;
    bit got, aborted;
    logic [31:0] rd;
    acc = 0; got = 0; aborted = 0;
    never_ready = 1;
    set_req(1, PADDIR, 1'b0, 32'h0);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE) acc++;
      if (acc == TO && PSEL && PENABLE && !aborted) begin
        aborted = 1;
        check("to_no_gnt_abort", 64'(gnt_o), 64'd0);
      end
      if (rvalid_o != '0) begin
        got = 1;
        check("to_access_cycles", 64'(acc), 64'(TO));
        check("to_psel_dropped", 64'({PSEL, PENABLE}), 64'b00);
        check("to_rvalid", 64'(rvalid_o), 64'b0010);
        check("to_err", 64'(err_o), 64'd1);
        check("to_rdata", 64'(rdata_o), 64'd0);
      end
      step();
      if (c == 0) set_req(3, PADOUT, 1'b1, $urandom);
      if (aborted) never_ready = 0;
    end
    check("to_done", 64'(got), 64'd1);
    wait_done("to_next", 4'b1000, 1'b0, acc2, rd);
    check("to_next_access", 64'(acc2), 64'd1);
    drain("to_drain");
  endtask

  task automatic test_random();
    bit fin;
    fin = 0;
    issued = 0;
    done_cnt = 0;
    rand_waits = 1;
    mode = 1;
    for (int i = 0; i < N; i++) budget[i] = 12;
    for (int c = 0; c < 4000 && !fin; c++) begin
      step();
      fin = (budget[0] == 0) && (budget[1] == 0) && (budget[2] == 0) && (budget[3] == 0) &&
            (req_i == '0) && (exp_q.size() == 0) && !PSEL;
    end
    check("rand_finish", 64'(fin), 64'd1);
    check("rand_count", 64'(done_cnt), 64'(issued));
    rand_waits = 0;
    waits = 0;
    mode = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    never_ready = 1;
    set_req(0, INTEN, 1'b0, 32'h0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE) seen = 1;
      else step();
    end
    check("rm_reached_access", 64'(seen), 64'd1);
    #2 HRESETn = 1'b0;
    #1;
    check_reset("rm");
    exp_q.delete();
    rr_last = N - 1;
    never_ready = 0;
    req_i = '0;
    repeat (2) begin
      @(negedge HCLK);
      check("rm_no_rvalid", 64'(rvalid_o), 64'd0);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    set_req(3, PADOUT, 1'b1, $urandom);
    set_req(0, INTEN, 1'b0, 32'h0);
    @(negedge HCLK);
    check("rm_first_gnt", 64'(gnt_o), 64'd1);
    drain("rm_drain");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    offs = '{PADDIR, PADIN, PADOUT, INTEN, INTTYPE0, INTTYPE1, INTSTATUS};
    req_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
    for (int i = 0; i < N; i++) budget[i] = 0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    reset_dut();
    mon_on = 1;
    test_single_write();
    test_read_waits();
    test_fairness();
    test_pslverr();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

endmodule
